// File: rtl/spectral_cmult_buf.sv
// Bin-by-bin complex multiplier: holds a DEPTH-entry coefficient spectrum and scales a streaming spectrum.
// Optional feature: define SPECMULT_SAT_EN to clamp results instead of two's-complement wrap.
module spectral_cmult_buf #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256,
    parameter int FRAC  = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             coef_clear,
    input  logic             coef_valid,
    input  logic [WIDTH-1:0] coef_real,
    input  logic [WIDTH-1:0] coef_img,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_real,
    input  logic [WIDTH-1:0] in_img,
    output logic             coef_loaded,
    output logic             drop_err,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_real,
    output logic [WIDTH-1:0] out_img,
    output logic             out_last,
    output logic             dbg_state_o
);
    // Handshake: single-cycle strobes, no backpressure; every accepted in_valid yields
    // exactly one out_valid three clocks later, in order.
    localparam int AW = $clog2(DEPTH);
    localparam int PW = 2 * WIDTH;
    localparam int SW = 2 * WIDTH + 1;
    localparam logic signed [SW-1:0] RND  = SW'(1) <<< (FRAC - 1);
    localparam logic signed [SW-1:0] MAXV = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
`ifdef SPECMULT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef enum logic {S_LOAD = 1'b0, S_RUN = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   widx_q, widx_d;
    logic [AW-1:0]   ridx_q, ridx_d;
    logic            drop_q, drop_d;
    logic            coef_we;
    logic            take;

    logic [2*WIDTH-1:0] coef_mem [DEPTH];
    logic [2*WIDTH-1:0] coef_rd;

    logic                    s1_valid_q, s1_last_q;
    logic signed [WIDTH-1:0] s1_re_q, s1_im_q, s1_cr_q, s1_ci_q;
    logic                    s2_valid_q, s2_last_q;
    logic signed [PW-1:0]    rr_q, ii_q, ri_q, ir_q;
    logic signed [SW-1:0]    sum_re, sum_im, shr_re, shr_im;
    logic                    out_valid_q, out_last_q;
    logic [WIDTH-1:0]        out_real_q, out_img_q;

    always_comb begin
        state_d = state_q;
        widx_d  = widx_q;
        ridx_d  = ridx_q;
        drop_d  = drop_q;
        coef_we = 1'b0;
        take    = 1'b0;
        if (coef_clear) begin
            state_d = S_LOAD;
            widx_d  = '0;
            ridx_d  = '0;
            drop_d  = 1'b0;
        end else if (state_q == S_LOAD) begin
            if (coef_valid) begin
                coef_we = 1'b1;
                widx_d  = widx_q + AW'(1);
                if (widx_q == AW'(DEPTH - 1)) state_d = S_RUN;
            end
            if (in_valid) drop_d = 1'b1;
        end else if (in_valid) begin
            take   = 1'b1;
            ridx_d = ridx_q + AW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_LOAD;
            widx_q  <= '0;
            ridx_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            widx_q  <= widx_d;
            ridx_q  <= ridx_d;
            drop_q  <= drop_d;
        end
    end

    // Coefficient RAM has no reset so it can map onto block memory.
    always_ff @(posedge clk) begin
        if (coef_we) coef_mem[widx_q] <= {coef_real, coef_img};
    end
    assign coef_rd = coef_mem[ridx_q];

    function automatic logic [WIDTH-1:0] fit(input logic signed [SW-1:0] v);
        if (SAT && (v > MAXV)) return {1'b0, {(WIDTH-1){1'b1}}};
        if (SAT && (v < MINV)) return {1'b1, {(WIDTH-1){1'b0}}};
        return v[WIDTH-1:0];
    endfunction

    always_comb begin
        sum_re = SW'(rr_q) - SW'(ii_q);
        sum_im = SW'(ri_q) + SW'(ir_q);
        shr_re = (sum_re + RND) >>> FRAC;
        shr_im = (sum_im + RND) >>> FRAC;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_re_q     <= '0;
            s1_im_q     <= '0;
            s1_cr_q     <= '0;
            s1_ci_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            rr_q        <= '0;
            ii_q        <= '0;
            ri_q        <= '0;
            ir_q        <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_real_q  <= '0;
            out_img_q   <= '0;
        end else begin
            s1_valid_q <= take;
            if (take) begin
                s1_last_q <= (ridx_q == AW'(DEPTH - 1));
                s1_re_q   <= $signed(in_real);
                s1_im_q   <= $signed(in_img);
                s1_cr_q   <= $signed(coef_rd[2*WIDTH-1:WIDTH]);
                s1_ci_q   <= $signed(coef_rd[WIDTH-1:0]);
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_last_q <= s1_last_q;
                rr_q      <= PW'(s1_re_q) * PW'(s1_cr_q);
                ii_q      <= PW'(s1_im_q) * PW'(s1_ci_q);
                ri_q      <= PW'(s1_re_q) * PW'(s1_ci_q);
                ir_q      <= PW'(s1_im_q) * PW'(s1_cr_q);
            end
            out_valid_q <= s2_valid_q;
            out_last_q  <= s2_valid_q & s2_last_q;
            if (s2_valid_q) begin
                out_real_q <= fit(shr_re);
                out_img_q  <= fit(shr_im);
            end
        end
    end

    assign coef_loaded = (state_q == S_RUN);
    assign drop_err    = drop_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign out_real    = out_real_q;
    assign out_img     = out_img_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spectral_cmult_buf.sv
// Scoreboard bench for spectral_cmult_buf: arithmetic reference model, queue of expected results, negedge monitor.
module tb_spectral_cmult_buf;
  localparam int W = 16;
  localparam int DEPTH = 256;
  localparam int FRAC = 15;
`ifdef SPECMULT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic coef_clear, coef_valid, in_valid;
  logic [W-1:0] coef_real, coef_img, in_real, in_img;
  logic coef_loaded, drop_err, out_valid, out_last, dbg_state;
  logic [W-1:0] out_real, out_img;

  spectral_cmult_buf #(.WIDTH(W), .DEPTH(DEPTH), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .coef_clear(coef_clear), .coef_valid(coef_valid),
    .coef_real(coef_real), .coef_img(coef_img), .in_valid(in_valid),
    .in_real(in_real), .in_img(in_img), .coef_loaded(coef_loaded),
    .drop_err(drop_err), .out_valid(out_valid), .out_real(out_real),
    .out_img(out_img), .out_last(out_last), .dbg_state_o(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int last_cnt = 0;

  logic [2*W:0] exp_q[$];
  int issue_q[$];

  // reference model state
  logic [W-1:0] m_cr[DEPTH];
  logic [W-1:0] m_ci[DEPTH];
  bit m_loaded, m_drop;
  int m_widx, m_ridx;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] fit_m(input longint v);
    longint hi, lo;
    hi = (longint'(1) <<< (W-1)) - 1;
    lo = -(longint'(1) <<< (W-1));
    if (SAT && v > hi) return hi[W-1:0];
    if (SAT && v < lo) return lo[W-1:0];
    return v[W-1:0];
  endfunction

  function automatic logic [2*W-1:0] cmul(input logic [W-1:0] a_r, a_i, c_r, c_i);
    longint ar, ai, cr, ci, re, im;
    ar = longint'($signed(a_r)); ai = longint'($signed(a_i));
    cr = longint'($signed(c_r)); ci = longint'($signed(c_i));
    re = (ar * cr - ai * ci + (longint'(1) <<< (FRAC-1))) >>> FRAC;
    im = (ar * ci + ai * cr + (longint'(1) <<< (FRAC-1))) >>> FRAC;
    return {fit_m(re), fit_m(im)};
  endfunction

  function automatic void model_reset();
    m_loaded = 0; m_drop = 0; m_widx = 0; m_ridx = 0;
    exp_q.delete();
    issue_q.delete();
  endfunction

  // driver: one clock of stimulus, model update, then status checks after the edge
  task automatic step(input bit clr, input bit cv, input logic [W-1:0] cr_v, ci_v,
                      input bit iv, input logic [W-1:0] ir_v, ii_v);
    bit n_loaded, n_drop;
    coef_clear = clr; coef_valid = cv; coef_real = cr_v; coef_img = ci_v;
    in_valid = iv; in_real = ir_v; in_img = ii_v;
    n_loaded = m_loaded; n_drop = m_drop;
    if (clr) begin
      n_loaded = 0; n_drop = 0; m_widx = 0; m_ridx = 0;
    end else if (!m_loaded) begin
      if (cv) begin
        m_cr[m_widx] = cr_v; m_ci[m_widx] = ci_v;
        if (m_widx == DEPTH-1) n_loaded = 1;
        m_widx = (m_widx + 1) % DEPTH;
      end
      if (iv) n_drop = 1;
    end else if (iv) begin
      exp_q.push_back({(m_ridx == DEPTH-1), cmul(ir_v, ii_v, m_cr[m_ridx], m_ci[m_ridx])});
      issue_q.push_back(cyc);
      m_ridx = (m_ridx + 1) % DEPTH;
    end
    @(posedge clk); #1;
    m_loaded = n_loaded; m_drop = n_drop;
    coef_clear = 0; coef_valid = 0; in_valid = 0;
    chk("coef_loaded", 64'(coef_loaded), 64'(m_loaded));
    chk("drop_err", 64'(drop_err), 64'(m_drop));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, '0, '0);
  endtask

  task automatic load_const(input logic [W-1:0] cr_v, ci_v);
    for (int i = 0; i < DEPTH; i++) step(0, 1, cr_v, ci_v, 0, '0, '0);
  endtask

  task automatic load_rand();
    for (int i = 0; i < DEPTH; i++)
      step(0, 1, W'($urandom_range(0, 65535)), W'($urandom_range(0, 65535)), 0, '0, '0);
  endtask

  task automatic stream_const(input int n, input logic [W-1:0] r, i_v);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 1, r, i_v);
  endtask

  task automatic stream_rand(input int n);
    for (int i = 0; i < n; i++)
      step(0, 0, '0, '0, 1, W'($urandom_range(0, 65535)), W'($urandom_range(0, 65535)));
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [2*W:0] e;
    int t;
    if (!rst) begin
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out got %0h/%0h want none", out_real, out_img);
        end else begin
          e = exp_q.pop_front();
          t = issue_q.pop_front();
          if ({out_last, out_real, out_img} !== e) begin
            errors++;
            $display("FAIL out_data got last=%0b %04h/%04h want last=%0b %04h/%04h",
                     out_last, out_real, out_img, e[2*W], e[2*W-1:W], e[W-1:0]);
          end
          checks++;
          if (cyc - t != 3) begin
            errors++;
            $display("FAIL latency got %0d want 3", cyc - t);
          end
          if (out_last) last_cnt++;
        end
      end else begin
        checks++;
        if (out_last !== 1'b0) begin
          errors++;
          $display("FAIL last_without_valid got %0b want 0", out_last);
        end
      end
    end
  end

  initial begin
    rst = 1; coef_clear = 0; coef_valid = 0; in_valid = 0;
    coef_real = '0; coef_img = '0; in_real = '0; in_img = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_last", 64'(out_last), 64'(0));
    chk("rst_out_real", 64'(out_real), 64'(0));
    chk("rst_out_img", 64'(out_img), 64'(0));
    chk("rst_coef_loaded", 64'(coef_loaded), 64'(0));
    chk("rst_drop_err", 64'(drop_err), 64'(0));
    rst = 0;
    idle(2);

    // samples in LOAD are dropped and flagged; clear resets the flag
    stream_rand(3);
    idle(4);
    step(1, 0, '0, '0, 0, '0, '0);

    // gain 0.5 on real axis
    load_const(16'h4000, 16'h0000);
    stream_const(4, 16'h2000, 16'h1000);
    step(0, 1, 16'h7777, 16'h7777, 0, '0, '0);
    stream_rand(12);
    idle(4);

    // clear cycle with coef_valid: the write must be discarded
    step(1, 1, 16'h1234, 16'h5678, 0, '0, '0);
    load_const(16'h4000, 16'h4000);
    stream_const(3, 16'h4000, 16'h4000);
    stream_rand(6);
    idle(4);

    // most-negative corner: wraps or saturates
    step(1, 0, '0, '0, 0, '0, '0);
    load_const(16'h8000, 16'h0000);
    stream_const(3, 16'h8000, 16'h0000);
    stream_const(2, 16'h8000, 16'h8000);
    stream_rand(4);
    idle(4);

    // two back-to-back frames, drop_err left sticky into RUN
    step(1, 0, '0, '0, 0, '0, '0);
    step(0, 0, '0, '0, 1, 16'h0101, 16'h0202);
    load_rand();
    last_cnt = 0;
    stream_rand(512);
    idle(5);
    chk("last_count_512", 64'(last_cnt), 64'(2));

    // mid-frame clear: in-flight results drain, sample on the clear cycle is discarded
    stream_rand(100);
    step(1, 0, '0, '0, 1, 16'h1111, 16'h2222);
    idle(5);
    chk("clear_drained", 64'(exp_q.size()), 64'(0));

    // asynchronous reset mid-stream
    load_rand();
    stream_rand(50);
    in_valid = 1;
    rst = 1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'(0));
    chk("arst_coef_loaded", 64'(coef_loaded), 64'(0));
    chk("arst_out_real", 64'(out_real), 64'(0));
    in_valid = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    load_rand();
    stream_rand(40);
    idle(8);
    chk("final_drained", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
